uart_tx_fifo_drain: RTL and testbench

//  - Downstream consumer of the echo-path byte FIFO.
//  - Pops one word whenever the FIFO is non-empty and serialises it onto the UART TX line.
//  - Frame format: 8N1-style; start bit, data LSB first, optional parity bit, then stop bit(s).
//  - Sole reader of the FIFO; drives its re input and samples its dataOut.

---
 rtl/uart_tx_fifo_drain.sv | 148 ++++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that drains a byte FIFO: pops a word whenever the FIFO is non-empty and sends it.
// Optional even parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_fifo_drain #(
   parameter int unsigned CLKS_PER_BIT = 104,
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fifo_empty,
   output logic             fifo_re,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             tx,
   output logic             busy
);

   localparam int unsigned BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BIT_W  = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   state_e              state_q, state_d;
   logic [BAUD_W-1:0]   baud_q, baud_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [WIDTH-1:0]    shreg_q, shreg_d;
   logic                tx_q, tx_d;
   logic                busy_q, busy_d;
   logic                bit_end;
`ifdef UART_TX_PARITY_EN
   logic                parity_q, parity_d;
`endif

   // The pop handshake must act in the same cycle IDLE sees data, so it stays combinational.
   assign fifo_re = (state_q == S_IDLE) & ~fifo_empty;
   assign tx      = tx_q;
   assign busy    = busy_q;
   assign bit_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

   // Next-state, counters and datapath
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            baud_d = '0;
            if (!fifo_empty) state_d = S_FETCH;
         end
         S_FETCH: begin
            shreg_d  = fifo_data;
            baud_d   = '0;
            bit_d    = '0;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_data;
`endif
            state_d  = S_START;
         end
         S_START: begin
            baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
            if (bit_end) begin
               bit_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
            if (bit_end) begin
               shreg_d = shreg_q >> 1;
               if (bit_q == BIT_W'(WIDTH - 1)) begin
                  bit_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
            if (bit_end) state_d = S_STOP;
         end
`endif
         S_STOP: begin
            baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
            if (bit_end) begin
               if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are derived from the next state so the registered line lines up with the state.
      busy_d = (state_d != S_IDLE);
      unique case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = parity_d;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shreg_q  <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shreg_q  <= shreg_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Self-checking bench for uart_tx_fifo_drain (CLKS_PER_BIT=4, WIDTH=8, STOP_BITS=1).
// Honours UART_TX_PARITY_EN to match the DUT build.
module tb_uart_tx_fifo_drain;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB  = 11;
`else
   localparam int NB  = 10;
`endif
   localparam int FLEN = NB * CPB;
   localparam int NS   = 150;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       fifo_empty;
   logic       fifo_re;
   logic [7:0] fifo_data = 8'h00;
   logic       tx;
   logic       busy;

   always #5 clk = ~clk;

   uart_tx_fifo_drain #(.CLKS_PER_BIT(4), .WIDTH(8), .STOP_BITS(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty),
      .fifo_re    (fifo_re),
      .fifo_data  (fifo_data),
      .tx         (tx),
      .busy       (busy)
   );

   // FIFO model: pushes from the stimulus, pops on fifo_re with data valid the next cycle
   logic [7:0] mem [0:63];
   int push_cnt = 0;
   int pop_cnt  = 0;
   int bad_pop  = 0;
   assign fifo_empty = (push_cnt == pop_cnt);

   always @(posedge clk) begin
      if (fifo_re) begin
         if (push_cnt == pop_cnt) bad_pop <= bad_pop + 1;
         else begin
            fifo_data <= mem[pop_cnt % 64];
            pop_cnt   <= pop_cnt + 1;
         end
      end
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   task automatic push(input logic [7:0] d);
      mem[push_cnt % 64] = d;
      push_cnt++;
   endtask

   typedef struct {
      logic [7:0]  data;
      logic [15:0] bits;  // bit i = line level during bit period i (start first)
      int          len;
   } vec_t;

   vec_t vecs [6];

   task automatic run_vec(input vec_t v);
      int p0, n, j;
      logic [15:0] got;
      p0  = pop_cnt;
      got = '0;
      @(negedge clk);
      push(v.data);
      #1;
      check("fifo_re_on_data", int'(fifo_re), 1);
      n = 0;
      while (tx && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("start_latency", n, 2);
      j = 0;
      while (busy && j < 200) begin
         if ((j % CPB) == CPB / 2 && (j / CPB) < NB) got[j / CPB] = tx;
         j++;
         @(negedge clk);
      end
      check("frame_bits", int'(got), int'(v.bits));
      check("frame_len", j, v.len);
      check("pops_per_frame", pop_cnt - p0, 1);
   endtask

   logic tx_s   [0:NS-1];
   logic busy_s [0:NS-1];
   int   s, i, z0, o, idle_b, z1, p0, cnt_re, cnt_tx0, cnt_busy;

   initial begin
      // even parity: A5->0 00->0 FF->0 07->1 03->0 81->0
`ifdef UART_TX_PARITY_EN
      vecs[0] = '{8'hA5, 16'h054A, 44};
      vecs[1] = '{8'h00, 16'h0400, 44};
      vecs[2] = '{8'hFF, 16'h05FE, 44};
      vecs[3] = '{8'h07, 16'h060E, 44};
      vecs[4] = '{8'h03, 16'h0406, 44};
      vecs[5] = '{8'h81, 16'h0502, 44};
`else
      vecs[0] = '{8'hA5, 16'h034A, 40};
      vecs[1] = '{8'h00, 16'h0200, 40};
      vecs[2] = '{8'hFF, 16'h03FE, 40};
      vecs[3] = '{8'h07, 16'h020E, 40};
      vecs[4] = '{8'h03, 16'h0206, 40};
      vecs[5] = '{8'h81, 16'h0302, 40};
`endif

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx", int'(tx), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_fifo_re", int'(fifo_re), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      foreach (vecs[k]) run_vec(vecs[k]);

      // back-to-back 0x00 then 0xFF
      p0 = pop_cnt;
      @(negedge clk);
      push(8'h00);
      push(8'hFF);
      for (int k = 0; k < NS; k++) begin
         @(negedge clk);
         tx_s[k]   = tx;
         busy_s[k] = busy;
      end
      s = 0;
      while (s < NS && tx_s[s]) s++;
      i = s; z0 = 0;
      while (i < NS && !tx_s[i]) begin z0++; i++; end
      o = 0; idle_b = 0;
      while (i < NS && tx_s[i]) begin
         o++;
         if (!busy_s[i]) idle_b++;
         i++;
      end
      z1 = 0;
      while (i < NS && !tx_s[i]) begin z1++; i++; end
      check("b2b_zero_run", z0, (NB == 11) ? 40 : 36);
      check("b2b_gap_high", o, 6);
      check("b2b_idle_cycles", idle_b, 1);
      check("b2b_second_start", z1, CPB);
      check("b2b_pops", pop_cnt - p0, 2);
      check("b2b_end_idle", int'(busy_s[NS-1]), 0);

      // FIFO held empty
      cnt_re = 0; cnt_tx0 = 0; cnt_busy = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (fifo_re) cnt_re++;
         if (!tx) cnt_tx0++;
         if (busy) cnt_busy++;
      end
      check("empty_fifo_re", cnt_re, 0);
      check("empty_tx_low", cnt_tx0, 0);
      check("empty_busy", cnt_busy, 0);

      // reset in the middle of data bit 3 of 0x3C
      @(negedge clk);
      push(8'h3C);
      i = 0;
      while (tx && i < 20) begin @(negedge clk); i++; end
      repeat (CPB + 3 * CPB + 2) @(negedge clk);
      check("bit3_busy", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_tx", int'(tx), 1);
      @(negedge clk);
      rst_n = 1'b1;

      // reset while the start bit is on the line: tx must rise without a clock edge
      @(negedge clk);
      push(8'h55);
      i = 0;
      while (tx && i < 20) begin @(negedge clk); i++; end
      check("start_bit_low", int'(tx), 0);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_tx_start", int'(tx), 1);
      check("async_rst_busy_start", int'(busy), 0);
      @(negedge clk);
      rst_n = 1'b1;

      cnt_re = 0; cnt_tx0 = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (fifo_re) cnt_re++;
         if (!tx || busy) cnt_tx0++;
      end
      check("post_rst_fifo_re", cnt_re, 0);
      check("post_rst_no_frame", cnt_tx0, 0);
      check("pop_while_empty", bad_pop, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
